// File: rtl/inverse_substitution_box_generator.sv
// Builds the inverse of a 16x16 forward S-box, one entry per clock, with a registered lookup port.
// Optional macro INV_SBOX_CHECK_EN adds a seen-bitmap that flags a non-bijective forward box.
module inverse_substitution_box_generator (
    input  logic                      clk,
    input  logic                      reset_bar,
    input  logic                      enable_bar,
    input  logic [0:15][0:15][7:0]    sbox,
    input  logic                      sbox_ready,
    input  logic [7:0]                inv_addr,
    output logic [0:15][0:15][7:0]    inv_sbox,
    output logic [7:0]                inv_data,
    output logic                      ready,
    output logic                      error
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUILD = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t                    state_r;
    state_t                    state_s;
    logic [7:0]                k_r;
    logic [7:0]                v_s;
    logic                      start_s;
    logic                      write_s;
    logic [0:15][0:15][7:0]    inv_r;
    logic [7:0]                inv_data_r;
    logic                      ready_r;

    assign v_s      = sbox[k_r[7:4]][k_r[3:0]];
    assign inv_sbox = inv_r;
    assign inv_data = inv_data_r;
    assign ready    = ready_r;

    // Next-state decode; enable_bar high freezes every transition and write.
    always_comb begin
        state_s = state_r;
        start_s = 1'b0;
        write_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (!enable_bar && sbox_ready) begin
                    state_s = BUILD;
                    start_s = 1'b1;
                end else begin
                    state_s = IDLE;
                end
            end
            BUILD: begin
                if (enable_bar) begin
                    state_s = BUILD;
                end else if (!sbox_ready) begin
                    state_s = IDLE;
                end else begin
                    write_s = 1'b1;
                    if (k_r == 8'hFF) begin
                        state_s = DONE;
                    end else begin
                        state_s = BUILD;
                    end
                end
            end
            DONE: begin
                if (!enable_bar && !sbox_ready) begin
                    state_s = IDLE;
                end else begin
                    state_s = DONE;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State, index, inverse table and lookup registers.
    always_ff @(posedge clk) begin
        if (!reset_bar) begin
            state_r    <= IDLE;
            k_r        <= 8'd0;
            inv_r      <= '0;
            inv_data_r <= 8'd0;
            ready_r    <= 1'b0;
        end else begin
            state_r    <= state_s;
            inv_data_r <= inv_r[inv_addr[7:4]][inv_addr[3:0]];
            ready_r    <= (state_s == DONE);
            if (start_s) begin
                k_r <= 8'd0;
            end else if (write_s) begin
                k_r <= k_r + 8'd1;
            end
            // Later writes to the same slot overwrite earlier ones.
            if (write_s) begin
                inv_r[v_s[7:4]][v_s[3:0]] <= k_r;
            end
        end
    end

`ifdef INV_SBOX_CHECK_EN
    logic [255:0] seen_r;
    logic         error_r;

    // Duplicate detection: a forward value produced twice means the box is not a bijection.
    always_ff @(posedge clk) begin
        if (!reset_bar) begin
            seen_r  <= '0;
            error_r <= 1'b0;
        end else if (start_s) begin
            seen_r  <= '0;
            error_r <= 1'b0;
        end else if (write_s) begin
            seen_r[v_s] <= 1'b1;
            if (seen_r[v_s]) begin
                error_r <= 1'b1;
            end
        end
    end

    assign error = error_r;
`else
    assign error = 1'b0;
`endif

endmodule
